// File: rtl/dtw_pkg.sv
// Shared types and constants for the DTW minimum tracker.
package dtw_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Infinity sentinel; users slice the low 'width' bits.
  localparam logic [63:0] COST_INF = '1;

endpackage

// File: rtl/dtw_min_tracker.sv
// Tracks the minimum final-row DTW cost and its first index over a job of len samples.
// Optional DTW_TRACK_STATS_EN adds out_hits, the count of accepted samples below thresh.
module dtw_min_tracker
  import dtw_pkg::*;
#(
  parameter int unsigned width = 18,
  parameter int unsigned IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] len,
  input  logic [width-1:0] thresh,
  input  logic             in_valid,
  input  logic [width-1:0] in_cost,
  output logic             in_ready,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] out_min,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_hit
`ifdef DTW_TRACK_STATS_EN
  ,
  output logic [IDX_W-1:0] out_hits
`endif
);

  localparam logic [width-1:0] INF = COST_INF[width-1:0];
  localparam logic [IDX_W-1:0] ONE = IDX_W'(1);

  state_t           state;
  logic [IDX_W-1:0] len_q;
  logic [width-1:0] thresh_q;
  logic [IDX_W-1:0] cnt;
  logic [width-1:0] min_q;
  logic [IDX_W-1:0] idx_q;
`ifdef DTW_TRACK_STATS_EN
  logic [IDX_W-1:0] hits_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      len_q    <= '0;
      thresh_q <= '0;
      cnt      <= '0;
      min_q    <= INF;
      idx_q    <= '0;
`ifdef DTW_TRACK_STATS_EN
      hits_q   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            len_q    <= len;
            thresh_q <= thresh;
            cnt      <= '0;
            min_q    <= INF;
            idx_q    <= '0;
`ifdef DTW_TRACK_STATS_EN
            hits_q   <= '0;
`endif
            state    <= (len == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (in_valid) begin
            // Strict compare keeps the earliest index on ties and rejects the sentinel.
            if (in_cost < min_q) begin
              min_q <= in_cost;
              idx_q <= cnt;
            end
`ifdef DTW_TRACK_STATS_EN
            if (in_cost < thresh_q) hits_q <= hits_q + ONE;
`endif
            cnt <= cnt + ONE;
            if (cnt == len_q - ONE) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == RUN);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_min   = min_q;
  assign out_idx   = idx_q;
  assign out_hit   = (min_q < thresh_q);
`ifdef DTW_TRACK_STATS_EN
  assign out_hits  = hits_q;
`endif

endmodule

// File: tb/tb_dtw_min_tracker.sv
// Self-checking bench for dtw_min_tracker; expected results queued per job, checked on out_valid.
module tb_dtw_min_tracker;

  localparam int W  = 18;
  localparam int IW = 16;
  localparam logic [W-1:0] INF = '1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [IW-1:0] len = '0;
  logic [W-1:0]  thresh = '0;
  logic          in_valid = 1'b0;
  logic [W-1:0]  in_cost = '0;
  logic          in_ready;
  logic          busy;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_min;
  logic [IW-1:0] out_idx;
  logic          out_hit;
`ifdef DTW_TRACK_STATS_EN
  logic [IW-1:0] out_hits;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [W-1:0]  min;
    logic [IW-1:0] idx;
    logic          hit;
  } exp_t;

  exp_t         sb[$];
  logic [W-1:0] cbuf[0:15];

  dtw_min_tracker #(.width(W), .IDX_W(IW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .thresh(thresh),
    .in_valid(in_valid), .in_cost(in_cost), .in_ready(in_ready), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min),
    .out_idx(out_idx), .out_hit(out_hit)
`ifdef DTW_TRACK_STATS_EN
    , .out_hits(out_hits)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input int n, input logic [W-1:0] th);
    exp_t e;
    e.min = INF;
    e.idx = '0;
    for (int i = 0; i < n; i++) begin
      if (cbuf[i] < e.min) begin
        e.min = cbuf[i];
        e.idx = IW'(i);
      end
    end
    e.hit = (e.min < th);
    return e;
  endfunction

  task automatic start_job(input logic [IW-1:0] l, input logic [W-1:0] th);
    start = 1'b1; len = l; thresh = th;
    tick();
    start = 1'b0; len = '0; thresh = '0;
  endtask

  task automatic send(input logic [W-1:0] c);
    in_valid = 1'b1; in_cost = c;
    tick();
    in_valid = 1'b0; in_cost = '0;
  endtask

  task automatic collect(input string name);
    int   waited;
    exp_t e;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 40) begin
      tick();
      waited++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL %s out_valid timeout: got %b want 1", name, out_valid);
    end
    e = sb.pop_front();
    checks++;
    if (out_min !== e.min) begin
      failures++;
      $display("FAIL %s out_min: got %0d want %0d", name, out_min, e.min);
    end
    checks++;
    if (out_idx !== e.idx) begin
      failures++;
      $display("FAIL %s out_idx: got %0d want %0d", name, out_idx, e.idx);
    end
    checks++;
    if (out_hit !== e.hit) begin
      failures++;
      $display("FAIL %s out_hit: got %b want %b", name, out_hit, e.hit);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL %s release: out_valid=%b busy=%b want 0 0", name, out_valid, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (2) tick();
    checks++;
    if ({out_valid, in_ready, busy, out_min, out_idx, out_hit} !== {1'b0, 1'b0, 1'b0, INF, {IW{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset_state: got v=%b r=%b b=%b min=%0h idx=%0d hit=%b want 0 0 0 %0h 0 0",
               out_valid, in_ready, busy, out_min, out_idx, out_hit, INF);
    end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic;
    start_job(16'd4, 18'd25);
    sb.push_back('{min: 18'd20, idx: 16'd1, hit: 1'b1});
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_run: busy=%b in_ready=%b want 1 1", busy, in_ready);
    end
    send(18'd50);
    send(18'd20);
    send(18'd30);
    in_valid = 1'b1; in_cost = 18'd20;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL basic_early_valid: got %b want 0", out_valid);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL basic_latency: got %b want 1", out_valid);
    end
    collect("basic");
  endtask

  task automatic test_zero_len;
    start_job(16'd0, 18'd100);
    sb.push_back('{min: INF, idx: 16'd0, hit: 1'b0});
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("FAIL zero_len_latency: got %b want 1", out_valid);
    end
    collect("zero_len");
  endtask

  task automatic test_stall;
    exp_t e;
    start_job(16'd3, 18'd5);
    e = '{min: 18'd4, idx: 16'd1, hit: 1'b1};
    sb.push_back(e);
    send(18'd9);
    tick();
    tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
    end
    send(18'd4);
    send(18'd6);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_min !== e.min || out_idx !== e.idx || out_hit !== e.hit) begin
        failures++;
        $display("FAIL stall_stable cycle %0d: v=%b min=%0d idx=%0d hit=%b want 1 %0d %0d %b",
                 i, out_valid, out_min, out_idx, out_hit, e.min, e.idx, e.hit);
      end
      tick();
    end
    collect("stall");
  endtask

  task automatic test_reset_mid;
    start_job(16'd5, 18'd50);
    send(18'd3);
    send(18'd2);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, in_ready, busy, out_min, out_idx, out_hit} !== {1'b0, 1'b0, 1'b0, INF, {IW{1'b0}}, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid: got v=%b r=%b b=%b min=%0h idx=%0d hit=%b want 0 0 0 %0h 0 0",
               out_valid, in_ready, busy, out_min, out_idx, out_hit, INF);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_discard: out_valid=%b busy=%b want 0 0", out_valid, busy);
    end
    start_job(16'd2, 18'd8);
    sb.push_back('{min: 18'd7, idx: 16'd0, hit: 1'b1});
    send(18'd7);
    send(18'd9);
    collect("after_reset");
  endtask

  task automatic test_ignore_start;
    start_job(16'd3, 18'd100);
    sb.push_back('{min: 18'd30, idx: 16'd2, hit: 1'b1});
    send(18'd40);
    start = 1'b1; len = 16'd1; thresh = 18'd5;
    tick();
    start = 1'b0;
    send(18'd60);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL ignore_start_run: out_valid=%b in_ready=%b want 0 1", out_valid, in_ready);
    end
    send(18'd30);
    start = 1'b1; len = 16'd2; thresh = 18'd0;
    tick();
    start = 1'b0; len = '0;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL ignore_start_done: out_valid=%b in_ready=%b want 1 0", out_valid, in_ready);
    end
    collect("ignore_start");
  endtask

  task automatic test_back_to_back;
    int           n;
    logic [W-1:0] th;
    for (int j = 0; j < 8; j++) begin
      n  = int'($urandom_range(1, 8));
      th = W'($urandom_range(0, 300));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 5) == 0) cbuf[i] = INF;
        else cbuf[i] = W'($urandom_range(0, 255));
      end
      if (j == 0) for (int i = 0; i < n; i++) cbuf[i] = INF;
      start_job(IW'(n), th);
      sb.push_back(model(n, th));
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) tick();
        send(cbuf[i]);
      end
      collect("back_to_back");
    end
  endtask

`ifdef DTW_TRACK_STATS_EN
  task automatic test_stats;
    start_job(16'd4, 18'd10);
    sb.push_back('{min: 18'd5, idx: 16'd0, hit: 1'b1});
    send(18'd5);
    send(18'd30);
    send(18'd8);
    send(18'd40);
    checks++;
    if (out_hits !== 16'd2) begin
      failures++;
      $display("FAIL stats_hits: got %0d want 2", out_hits);
    end
    collect("stats");
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_stall();
    test_reset_mid();
    test_ignore_start();
    test_back_to_back();
`ifdef DTW_TRACK_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
